// File: rtl/vga_text_scheduler_pkg.sv
// Shared geometry defaults, control codes and helpers for the VGA text scheduler.
package vga_text_pkg;

  localparam int unsigned DEF_SLOTS   = 5;
  localparam int unsigned DEF_X0      = 20;
  localparam int unsigned DEF_PITCH   = 50;
  localparam int unsigned DEF_GLYPH_W = 30;
  localparam int unsigned DEF_GLYPH_H = 120;
  localparam int unsigned DEF_ROW0_Y  = 0;
  localparam int unsigned DEF_ROW1_Y  = 180;
  localparam bit          DEF_SCROLL  = 1'b1;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_CLR   = 8'h0C;

  typedef enum logic {
    RR_TX = 1'b0,
    RR_RX = 1'b1
  } rr_t;

  function automatic logic isPrintable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  // lo <= pos < lo+span, done with an 11-bit difference so a zero origin needs no special case
  function automatic logic inSpan(input logic [9:0] pos, input logic [9:0] lo, input logic [9:0] span);
    logic [10:0] d;
    d = {1'b0, pos} - {1'b0, lo};
    return !d[10] && (d[9:0] < span);
  endfunction

endpackage

// File: rtl/vga_text_scheduler_if.sv
// Character write handshake from the morse TX/RX decoders into the scheduler.
interface vga_text_scheduler_if;
  logic       iTX_valid;
  logic [7:0] iTX_char;
  logic       oTX_ready;
  logic       iRX_valid;
  logic [7:0] iRX_char;
  logic       oRX_ready;

  modport master (output iTX_valid, iTX_char, iRX_valid, iRX_char,
                  input  oTX_ready, oRX_ready);
  modport slave  (input  iTX_valid, iTX_char, iRX_valid, iRX_char,
                  output oTX_ready, oRX_ready);
endinterface

// File: rtl/vga_text_scheduler_text_row_buffer.sv
// One row of character slots with a write cursor, scroll/wrap handling and an async read port.
module text_row_buffer
  import vga_text_pkg::*;
#(
  parameter int unsigned SLOTS  = DEF_SLOTS,
  parameter bit          SCROLL = DEF_SCROLL,
  localparam int unsigned IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic          iVGA_CLK,
  input  logic          iRST_n,
  input  logic          iWrEn,
  input  logic [7:0]    iWrChar,
  input  logic [IW-1:0] iRdSlot,
  output logic [7:0]    oRdChar
);

  localparam int unsigned CW = $clog2(SLOTS + 1);

  logic [7:0]    slots [SLOTS];
  logic [CW-1:0] cursor;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < int'(SLOTS); i++) slots[i] <= CH_SPACE;
      cursor <= '0;
    end else if (iWrEn) begin
      if (isPrintable(iWrChar)) begin
        if (cursor < CW'(SLOTS)) begin
          for (int i = 0; i < int'(SLOTS); i++)
            if (CW'(i) == cursor) slots[i] <= iWrChar;
          cursor <= cursor + CW'(1);
        end else if (SCROLL) begin
          for (int i = 0; i < int'(SLOTS) - 1; i++) slots[i] <= slots[i+1];
          slots[SLOTS-1] <= iWrChar;
        end else begin
          slots[0] <= iWrChar;
          cursor   <= CW'(1);
        end
      end else if (iWrChar == CH_BS) begin
        if (cursor != '0) begin
          for (int i = 0; i < int'(SLOTS); i++)
            if (CW'(i + 1) == cursor) slots[i] <= CH_SPACE;
          cursor <= cursor - CW'(1);
        end
      end else if (iWrChar == CH_CLR) begin
        for (int i = 0; i < int'(SLOTS); i++) slots[i] <= CH_SPACE;
        cursor <= '0;
      end
    end
  end

  always_comb begin
    oRdChar = CH_SPACE;
    for (int i = 0; i < int'(SLOTS); i++)
      if (IW'(i) == iRdSlot) oRdChar = slots[i];
  end

endmodule

// File: rtl/vga_text_scheduler.sv
// Arbitrates decoder writes into the TX/RX rows and maps each pixel to a glyph cell for the renderer.
module vga_text_scheduler
  import vga_text_pkg::*;
#(
  parameter int unsigned SLOTS   = DEF_SLOTS,
  parameter int unsigned X0      = DEF_X0,
  parameter int unsigned PITCH   = DEF_PITCH,
  parameter int unsigned GLYPH_W = DEF_GLYPH_W,
  parameter int unsigned GLYPH_H = DEF_GLYPH_H,
  parameter int unsigned ROW0_Y  = DEF_ROW0_Y,
  parameter int unsigned ROW1_Y  = DEF_ROW1_Y,
  parameter bit          SCROLL  = DEF_SCROLL
) (
  input  logic                       iVGA_CLK,
  input  logic                       iRST_n,
  vga_text_scheduler_if.slave        wr,
  input  logic [9:0]                 iVGA_X,
  input  logic [9:0]                 iVGA_Y,
  output logic                       oActive,
  output logic                       oRow,
  output logic [7:0]                 oChar,
  output logic [$clog2(GLYPH_W)-1:0] oLocalX,
  output logic [$clog2(GLYPH_H)-1:0] oLocalY
);

  localparam int unsigned IW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned LXW = $clog2(GLYPH_W);
  localparam int unsigned LYW = $clog2(GLYPH_H);

  rr_t rrState, rrNext;
  logic grantTx, grantRx;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) rrState <= RR_TX;
    else         rrState <= rrNext;
  end

  // Round-robin grant; the pointer moves to the other source after every transfer
  always_comb begin
    rrNext  = rrState;
    grantTx = 1'b0;
    grantRx = 1'b0;
    if (wr.iTX_valid && (!wr.iRX_valid || rrState == RR_TX)) grantTx = 1'b1;
    else if (wr.iRX_valid)                                   grantRx = 1'b1;
    if (grantTx) rrNext = RR_RX;
    if (grantRx) rrNext = RR_TX;
  end

  assign wr.oTX_ready = grantTx;
  assign wr.oRX_ready = grantRx;

  logic          rowTxHit, rowRxHit, slotHit;
  logic [IW-1:0] slotIdx;
  logic [LXW-1:0] localX;
  logic [LYW-1:0] localY;
  logic [7:0]    txRd, rxRd;

  text_row_buffer #(.SLOTS(SLOTS), .SCROLL(SCROLL)) uTxRow (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iWrEn(grantTx), .iWrChar(wr.iTX_char),
    .iRdSlot(slotIdx), .oRdChar(txRd)
  );

  text_row_buffer #(.SLOTS(SLOTS), .SCROLL(SCROLL)) uRxRow (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iWrEn(grantRx), .iWrChar(wr.iRX_char),
    .iRdSlot(slotIdx), .oRdChar(rxRd)
  );

  // Parallel cell compares; TX row wins if the rows overlap
  always_comb begin
    rowTxHit = inSpan(iVGA_Y, 10'(ROW0_Y), 10'(GLYPH_H));
    rowRxHit = inSpan(iVGA_Y, 10'(ROW1_Y), 10'(GLYPH_H));
    slotHit  = 1'b0;
    slotIdx  = '0;
    localX   = '0;
    for (int k = 0; k < int'(SLOTS); k++) begin
      if (!slotHit && inSpan(iVGA_X, 10'(X0 + k * PITCH), 10'(GLYPH_W))) begin
        slotHit = 1'b1;
        slotIdx = IW'(k);
        localX  = LXW'(iVGA_X - 10'(X0 + k * PITCH));
      end
    end
    localY = rowTxHit ? LYW'(iVGA_Y - 10'(ROW0_Y)) : LYW'(iVGA_Y - 10'(ROW1_Y));
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oActive <= 1'b0;
      oRow    <= 1'b0;
      oChar   <= '0;
      oLocalX <= '0;
      oLocalY <= '0;
    end else if (slotHit && (rowTxHit || rowRxHit)) begin
      oActive <= 1'b1;
      oRow    <= !rowTxHit;
      oChar   <= rowTxHit ? txRd : rxRd;
      oLocalX <= localX;
      oLocalY <= localY;
    end else begin
      oActive <= 1'b0;
      oRow    <= 1'b0;
      oChar   <= '0;
      oLocalX <= '0;
      oLocalY <= '0;
    end
  end

endmodule

// File: tb/tb_vga_text_scheduler.sv
// Bench for vga_text_scheduler: a scrolling and a wrapping instance against one row/arbiter model.
module tb_vga_text_scheduler;
  import vga_text_pkg::*;

  localparam int NS = DEF_SLOTS;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       txValid = 1'b0, rxValid = 1'b0;
  logic [7:0] txChar = 8'h00, rxChar = 8'h00;
  logic [9:0] vgaX = '0, vgaY = '0;

  always #5 clk = ~clk;

  vga_text_scheduler_if ifA ();
  vga_text_scheduler_if ifB ();
  assign ifA.iTX_valid = txValid;  assign ifB.iTX_valid = txValid;
  assign ifA.iTX_char  = txChar;   assign ifB.iTX_char  = txChar;
  assign ifA.iRX_valid = rxValid;  assign ifB.iRX_valid = rxValid;
  assign ifA.iRX_char  = rxChar;   assign ifB.iRX_char  = rxChar;

  logic       actA, rowA, actB, rowB;
  logic [7:0] chA, chB;
  logic [4:0] lxA, lxB;
  logic [6:0] lyA, lyB;

  vga_text_scheduler #(.SCROLL(1'b1)) dutA (
    .iVGA_CLK(clk), .iRST_n(rstN), .wr(ifA.slave), .iVGA_X(vgaX), .iVGA_Y(vgaY),
    .oActive(actA), .oRow(rowA), .oChar(chA), .oLocalX(lxA), .oLocalY(lyA));

  vga_text_scheduler #(.SCROLL(1'b0)) dutB (
    .iVGA_CLK(clk), .iRST_n(rstN), .wr(ifB.slave), .iVGA_X(vgaX), .iVGA_Y(vgaY),
    .oActive(actB), .oRow(rowB), .oChar(chB), .oLocalX(lxB), .oLocalY(lyB));

  int nCmp = 0, nErr = 0;

  // Model: variant 0 scrolls, variant 1 wraps; [variant][row][slot]
  logic [7:0] mem [2][2][NS];
  int         cur [2][2];
  int         mRr;
  logic       lastGT, lastGR;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mReset();
    for (int v = 0; v < 2; v++) for (int r = 0; r < 2; r++) begin
      cur[v][r] = 0;
      for (int k = 0; k < NS; k++) mem[v][r][k] = 8'h20;
    end
    mRr = 0;
  endfunction

  function automatic void mWrite(input int v, input int r, input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      if (cur[v][r] < NS) begin
        mem[v][r][cur[v][r]] = ch;
        cur[v][r]++;
      end else if (v == 0) begin
        for (int k = 0; k < NS - 1; k++) mem[v][r][k] = mem[v][r][k+1];
        mem[v][r][NS-1] = ch;
      end else begin
        mem[v][r][0] = ch;
        cur[v][r] = 1;
      end
    end else if (ch == 8'h08) begin
      if (cur[v][r] > 0) begin
        cur[v][r]--;
        mem[v][r][cur[v][r]] = 8'h20;
      end
    end else if (ch == 8'h0C) begin
      for (int k = 0; k < NS; k++) mem[v][r][k] = 8'h20;
      cur[v][r] = 0;
    end
  endfunction

  function automatic logic [21:0] mPix(input int v, input int x, input int y);
    int r, top, k, off;
    if (y >= DEF_ROW0_Y && y < DEF_ROW0_Y + DEF_GLYPH_H) begin r = 0; top = DEF_ROW0_Y; end
    else if (y >= DEF_ROW1_Y && y < DEF_ROW1_Y + DEF_GLYPH_H) begin r = 1; top = DEF_ROW1_Y; end
    else return '0;
    if (x < DEF_X0) return '0;
    k   = (x - DEF_X0) / DEF_PITCH;
    off = (x - DEF_X0) % DEF_PITCH;
    if (k >= NS || off >= DEF_GLYPH_W) return '0;
    return {1'b1, (r == 1), mem[v][r][k], 5'(off), 7'(y - top)};
  endfunction

  // One clock: check readies, predict registered pixel outputs, update model, advance
  task automatic tick();
    logic gT, gR;
    logic [21:0] eA, eB;
    #1;
    if (txValid && rxValid) begin gT = (mRr == 0); gR = (mRr == 1); end
    else begin gT = txValid; gR = rxValid; end
    chk("ready_scroll", {ifA.oTX_ready, ifA.oRX_ready}, {gT, gR});
    chk("ready_wrap",   {ifB.oTX_ready, ifB.oRX_ready}, {gT, gR});
    eA = mPix(0, int'(vgaX), int'(vgaY));
    eB = mPix(1, int'(vgaX), int'(vgaY));
    if (gT) begin mWrite(0, 0, txChar); mWrite(1, 0, txChar); mRr = 1; end
    if (gR) begin mWrite(0, 1, rxChar); mWrite(1, 1, rxChar); mRr = 0; end
    lastGT = gT; lastGR = gR;
    @(posedge clk); #1;
    chk("pix_scroll", {actA, rowA, chA, lxA, lyA}, eA);
    chk("pix_wrap",   {actB, rowB, chB, lxB, lyB}, eB);
  endtask

  task automatic sendTx(input logic [7:0] c);
    txValid = 1'b1; txChar = c; tick(); txValid = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] c);
    rxValid = 1'b1; rxChar = c; tick(); rxValid = 1'b0;
  endtask

  task automatic checkRow(input string nm, input int r, input logic [7:0] ea [NS], input logic [7:0] eb [NS]);
    for (int k = 0; k < NS; k++) begin
      vgaX = 10'(DEF_X0 + k * DEF_PITCH);
      vgaY = 10'((r == 0) ? DEF_ROW0_Y : DEF_ROW1_Y);
      tick();
      chk({nm, "_scroll"}, chA, ea[k]);
      chk({nm, "_wrap"},   chB, eb[k]);
    end
  endtask

  function automatic logic [7:0] randChar();
    int s;
    s = int'($urandom_range(0, 15));
    if (s == 0) return 8'h08;
    if (s == 1) return 8'h0C;
    if (s == 2) return 8'h00;
    if (s == 3) return 8'h7F;
    if (s == 4) return 8'h0A;
    return 8'(8'h20 + $urandom_range(0, 94));
  endfunction

  typedef struct {
    int         x;
    int         y;
    logic       act;
    logic       row;
    logic [4:0] lx;
    logic [6:0] ly;
  } pvec_t;

  initial begin
    pvec_t      tbl [13];
    logic [7:0] sp [NS];
    logic [7:0] ea [NS];
    logic [7:0] eb [NS];
    logic [7:0] hello [5];

    tbl[0]  = '{20,  0,   1'b1, 1'b0, 5'd0,  7'd0};
    tbl[1]  = '{19,  0,   1'b0, 1'b0, 5'd0,  7'd0};
    tbl[2]  = '{49,  119, 1'b1, 1'b0, 5'd29, 7'd119};
    tbl[3]  = '{50,  0,   1'b0, 1'b0, 5'd0,  7'd0};
    tbl[4]  = '{70,  10,  1'b1, 1'b0, 5'd0,  7'd10};
    tbl[5]  = '{239, 5,   1'b1, 1'b0, 5'd19, 7'd5};
    tbl[6]  = '{250, 5,   1'b0, 1'b0, 5'd0,  7'd0};
    tbl[7]  = '{270, 5,   1'b0, 1'b0, 5'd0,  7'd0};
    tbl[8]  = '{20,  120, 1'b0, 1'b0, 5'd0,  7'd0};
    tbl[9]  = '{20,  180, 1'b1, 1'b1, 5'd0,  7'd0};
    tbl[10] = '{49,  299, 1'b1, 1'b1, 5'd29, 7'd119};
    tbl[11] = '{20,  300, 1'b0, 1'b0, 5'd0,  7'd0};
    tbl[12] = '{639, 479, 1'b0, 1'b0, 5'd0,  7'd0};
    for (int k = 0; k < NS; k++) sp[k] = 8'h20;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    mReset();
    #1;
    chk("reset_outputs_a", {actA, rowA, chA, lxA, lyA}, 32'h0);
    chk("reset_outputs_b", {actB, rowB, chB, lxB, lyB}, 32'h0);
    #12 rstN = 1'b1;
    @(posedge clk); #1;

    // Geometry table after reset
    foreach (tbl[i]) begin
      vgaX = 10'(tbl[i].x); vgaY = 10'(tbl[i].y);
      tick();
      chk("geom_tbl", {actA, rowA, chA, lxA, lyA},
          {tbl[i].act, tbl[i].row, tbl[i].act ? 8'h20 : 8'h00, tbl[i].lx, tbl[i].ly});
    end

    // Scanline sweep
    for (int x = 0; x < 640; x++) begin
      vgaX = 10'(x); vgaY = 10'd10;
      tick();
    end

    // Both sources valid: TX, RX, TX, RX from a fresh pointer
    txValid = 1'b1; txChar = 8'h61; rxValid = 1'b1; rxChar = 8'h31;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_order", {ifA.oTX_ready, ifA.oRX_ready}, (i % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      if (lastGT) txChar = 8'h62;
      if (lastGR) rxChar = 8'h32;
    end
    txValid = 1'b0; rxValid = 1'b0;
    sendTx(8'h0C); sendRx(8'h0C);

    // HELLO then read the 'E' cell
    foreach (hello[i]) sendTx(hello[i]);
    vgaX = 10'd75; vgaY = 10'd50;
    tick();
    chk("hello_E", {actA, rowA, chA, lxA, lyA}, {1'b1, 1'b0, 8'h45, 5'd5, 7'd50});

    // Overflow: scroll vs wrap
    for (int i = 0; i < 6; i++) sendRx(8'(8'h41 + i));
    ea = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    eb = '{8'h46, 8'h42, 8'h43, 8'h44, 8'h45};
    checkRow("overflow", 1, ea, eb);

    // Backspace / clear
    sendTx(8'h0C); sendTx(8'h41); sendTx(8'h42); sendTx(8'h08);
    ea = '{8'h41, 8'h20, 8'h20, 8'h20, 8'h20};
    checkRow("bs", 0, ea, ea);
    sendTx(8'h0C);
    checkRow("clr", 0, sp, sp);
    sendTx(8'h08);
    checkRow("bs_at_0", 0, sp, sp);
    sendTx(8'h51);
    ea = '{8'h51, 8'h20, 8'h20, 8'h20, 8'h20};
    checkRow("cursor_0", 0, ea, ea);

    // Randomised traffic with the loser holding its character
    for (int n = 0; n < 500; n++) begin
      if (!txValid || lastGT) begin txValid = 1'($urandom_range(0, 1)); txChar = randChar(); end
      if (!rxValid || lastGR) begin rxValid = 1'($urandom_range(0, 1)); rxChar = randChar(); end
      vgaX = 10'($urandom_range(0, 639));
      vgaY = 10'($urandom_range(0, 479));
      tick();
    end
    txValid = 1'b0; rxValid = 1'b0;

    // Reset during a granted write
    sendTx(8'h0C); sendTx(8'h4B);
    vgaX = 10'd20; vgaY = 10'd0;
    tick();
    chk("pre_reset_active", {actA, chA}, {1'b1, 8'h4B});
    txValid = 1'b1; txChar = 8'h5A;
    #2 rstN = 1'b0;
    #1;
    chk("mid_reset_a", {actA, rowA, chA, lxA, lyA}, 32'h0);
    chk("mid_reset_b", {actB, rowB, chB, lxB, lyB}, 32'h0);
    txValid = 1'b0;
    @(negedge clk) rstN = 1'b1;
    mReset();
    @(posedge clk); #1;
    checkRow("post_reset_tx", 0, sp, sp);
    checkRow("post_reset_rx", 1, sp, sp);
    txValid = 1'b1; txChar = 8'h54; rxValid = 1'b1; rxChar = 8'h55;
    #1;
    chk("post_reset_rr", {ifA.oTX_ready, ifA.oRX_ready}, 32'h2);
    tick();
    txValid = 1'b0; rxValid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
